dlx_encoder: RTL and testbench

Inverse of the DLX instruction decoder. Accepts one decoded control tuple per handshake (ALU code, register indices, 32-bit immediate, memory/PC control flags) and re-encodes it into the canonical 32-bit DLX R/I/J instruction word. Each valid word is emitted through a one-deep registered valid/ready output stage, together with an auto-incrementing instruction-memory address. Used by the boot loader, the self-test program generator and the decoder round-trip bench.

---
 rtl/dlx_encoder.sv | 162 ++++++++++++++++
 tb/tb_dlx_encoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_encoder.sv
// Re-encodes a decoded DLX control tuple into a 32-bit R/I/J word behind a one-deep valid/ready stage.
// Optional: define ENCODER_RANGE_CHECK_EN to reject immediates that do not fit their instruction field.
module dlx_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        I,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [4:0]        Rd,
  input  logic [31:0]       Iv,
  input  logic              d_load_enable,
  input  logic              d_write_enable,
  input  logic              Iv_alu,
  input  logic              Pc_alu,
  input  logic [1:0]        Pc_cmd,
  input  logic [1:0]        Pc_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IMM_NONE, IMM_SIGN, IMM_ZERO, IMM_JUMP} imm_cls_t;

  logic       alu_hit;
  logic       alu_sext;
  logic [5:0] alu_funct;
  logic [5:0] alu_iop;
  logic       op_ok;
  logic       range_ok;
  logic       enc_ok;
  logic [5:0] i_op;
  logic [31:0] enc_word;
  imm_cls_t   imm_cls;
  logic       accept;
  logic       j_form;

  always_comb begin
    alu_hit   = 1'b1;
    alu_sext  = 1'b0;
    alu_funct = 6'h00;
    alu_iop   = 6'h00;
    case (I)
      4'd1:    begin alu_funct = 6'h20; alu_iop = 6'h08; alu_sext = 1'b1; end
      4'd2:    begin alu_funct = 6'h22; alu_iop = 6'h0a; alu_sext = 1'b1; end
      4'd3:    begin alu_funct = 6'h24; alu_iop = 6'h0c; end
      4'd4:    begin alu_funct = 6'h25; alu_iop = 6'h0d; end
      4'd5:    begin alu_funct = 6'h26; alu_iop = 6'h0e; end
      4'd6:    begin alu_funct = 6'h04; alu_iop = 6'h14; end
      4'd7:    begin alu_funct = 6'h06; alu_iop = 6'h16; end
      4'd10:   begin alu_funct = 6'h28; alu_iop = 6'h18; alu_sext = 1'b1; end
      4'd11:   begin alu_funct = 6'h2c; alu_iop = 6'h1c; alu_sext = 1'b1; end
      4'd12:   begin alu_funct = 6'h2a; alu_iop = 6'h1a; alu_sext = 1'b1; end
      4'd13:   begin alu_funct = 6'h29; alu_iop = 6'h19; alu_sext = 1'b1; end
      4'd14:   begin alu_funct = 6'h07; alu_iop = 6'h17; end
      default: alu_hit = 1'b0;
    endcase
  end

  assign j_form = (Pc_cmd == 2'b10) && (Pc_val == 2'b01);

  // Classification in priority order: PC-relative jumps, then R-type, then I-type special cases.
  always_comb begin
    op_ok    = 1'b0;
    enc_word = 32'h0;
    imm_cls  = IMM_NONE;
    i_op     = 6'h00;
    if (Pc_alu) begin
      if (j_form && I == 4'd15 && Rd == 5'd31) begin
        op_ok    = 1'b1;
        enc_word = {6'h03, Iv[25:0]};
        imm_cls  = IMM_JUMP;
      end else if (j_form && I == 4'd0 && Rd == 5'd0) begin
        op_ok    = 1'b1;
        enc_word = {6'h02, Iv[25:0]};
        imm_cls  = IMM_JUMP;
      end
    end else if (!Iv_alu) begin
      op_ok    = alu_hit;
      enc_word = {6'h00, Rs1, Rs2, Rd, 5'h00, alu_funct};
    end else begin
      op_ok   = 1'b1;
      imm_cls = IMM_SIGN;
      if (Pc_cmd == 2'b10 && I == 4'd8) begin
        i_op = 6'h04;
      end else if (Pc_cmd == 2'b10 && I == 4'd9) begin
        i_op = 6'h05;
      end else if (Pc_cmd == 2'b11 && I == 4'd15) begin
        i_op    = 6'h13;
        imm_cls = IMM_ZERO;
      end else if (Pc_cmd == 2'b11 && I == 4'd0) begin
        i_op    = 6'h12;
        imm_cls = IMM_ZERO;
      end else if (d_load_enable && I == 4'd1) begin
        i_op = 6'h23;
      end else if (d_write_enable && I == 4'd1) begin
        i_op = 6'h2b;
      end else if (I == 4'd0) begin
        i_op    = 6'h0f;
        imm_cls = IMM_ZERO;
      end else begin
        i_op    = alu_iop;
        op_ok   = alu_hit;
        imm_cls = alu_sext ? IMM_SIGN : IMM_ZERO;
      end
      enc_word = {i_op, Rs1, Rs2, Iv[15:0]};
    end
  end

`ifdef ENCODER_RANGE_CHECK_EN
  always_comb begin
    case (imm_cls)
      IMM_SIGN: range_ok = (Iv[31:16] == {16{Iv[15]}});
      IMM_ZERO: range_ok = (Iv[31:16] == 16'h0);
      IMM_JUMP: range_ok = (Iv[31:26] == {6{Iv[25]}});
      default:  range_ok = 1'b1;
    endcase
  end
`else
  logic [1:0] unused_range;
  assign unused_range = {^Iv[31:26], imm_cls == IMM_NONE};
  assign range_ok     = 1'b1;
`endif

  assign enc_ok   = op_ok && range_ok;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A rejected tuple is consumed but leaves the output stage empty, so a concurrent drain still empties it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_word  <= 32'h0;
      out_addr  <= BASE_ADDR;
      err       <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_addr  <= out_addr + ADDR_STEP;
      end
      if (accept) begin
        if (enc_ok) begin
          out_valid <= 1'b1;
          out_word  <= enc_word;
        end else begin
          err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_dlx_encoder.sv
// Self-checking bench for dlx_encoder: directed scenarios plus randomized traffic against a
// table-driven reference model of the DLX encoding rules.
module tb_dlx_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  I;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [31:0] Iv;
  logic        d_load_enable, d_write_enable, Iv_alu, Pc_alu;
  logic [1:0]  Pc_cmd, Pc_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0]  i;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] iv;
    logic        dle, dwe, iv_alu, pc_alu;
    logic [1:0]  pc_cmd, pc_val;
  } tuple_t;

  // -1 marks ALU codes with no encoding; sext marks sign-extended immediate classes.
  int funct_tab [16] = '{-1, 'h20, 'h22, 'h24, 'h25, 'h26, 'h04, 'h06, -1, -1, 'h28, 'h2c, 'h2a, 'h29, 'h07, -1};
  int iop_tab   [16] = '{-1, 'h08, 'h0a, 'h0c, 'h0d, 'h0e, 'h14, 'h16, -1, -1, 'h18, 'h1c, 'h1a, 'h19, 'h17, -1};
  bit sext_tab  [16] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  dlx_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ADDR_STEP(32'h4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .I(I), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Iv(Iv),
    .d_load_enable(d_load_enable), .d_write_enable(d_write_enable),
    .Iv_alu(Iv_alu), .Pc_alu(Pc_alu), .Pc_cmd(Pc_cmd), .Pc_val(Pc_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic tuple_t blank();
    tuple_t t;
    t = '{i: 4'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, iv: 32'd0, dle: 1'b0, dwe: 1'b0,
          iv_alu: 1'b0, pc_alu: 1'b0, pc_cmd: 2'd0, pc_val: 2'd0};
    return t;
  endfunction

  task automatic set_tuple(input tuple_t t);
    I = t.i; Rs1 = t.rs1; Rs2 = t.rs2; Rd = t.rd; Iv = t.iv;
    d_load_enable = t.dle; d_write_enable = t.dwe; Iv_alu = t.iv_alu;
    Pc_alu = t.pc_alu; Pc_cmd = t.pc_cmd; Pc_val = t.pc_val;
  endtask

  // Reference encoder: cls 1 = sign-extended, 2 = zero-extended, 3 = jump target.
  function automatic void ref_encode(input tuple_t t, output bit ok, output logic [31:0] w);
    int op;
    int cls;
    bit sx;
    ok = 0; w = 32'h0; cls = 0; op = -1; sx = 0;
    if (t.pc_alu) begin
      if (t.pc_cmd == 2'b10 && t.pc_val == 2'b01 &&
          ((t.i == 15 && t.rd == 31) || (t.i == 0 && t.rd == 0))) begin
        ok = 1; cls = 3;
        w = {(t.i == 15) ? 6'h03 : 6'h02, t.iv[25:0]};
      end
    end else if (!t.iv_alu) begin
      if (funct_tab[t.i] >= 0) begin
        ok = 1;
        w = {6'h00, t.rs1, t.rs2, t.rd, 5'h00, 6'(funct_tab[t.i])};
      end
    end else begin
      if      (t.pc_cmd == 2'b10 && t.i == 8)  begin op = 'h04; sx = 1; end
      else if (t.pc_cmd == 2'b10 && t.i == 9)  begin op = 'h05; sx = 1; end
      else if (t.pc_cmd == 2'b11 && t.i == 15) begin op = 'h13; sx = 0; end
      else if (t.pc_cmd == 2'b11 && t.i == 0)  begin op = 'h12; sx = 0; end
      else if (t.dle && t.i == 1)              begin op = 'h23; sx = 1; end
      else if (t.dwe && t.i == 1)              begin op = 'h2b; sx = 1; end
      else if (t.i == 0)                       begin op = 'h0f; sx = 0; end
      else begin op = iop_tab[t.i]; sx = sext_tab[t.i]; end
      if (op >= 0) begin
        ok = 1; cls = sx ? 1 : 2;
        w = {6'(op), t.rs1, t.rs2, t.iv[15:0]};
      end
    end
`ifdef ENCODER_RANGE_CHECK_EN
    if (ok) begin
      case (cls)
        1: ok = (t.iv[31:16] == {16{t.iv[15]}});
        2: ok = (t.iv[31:16] == 16'h0);
        3: ok = (t.iv[31:26] == {6{t.iv[25]}});
        default: ;
      endcase
    end
`endif
  endfunction

  function automatic tuple_t rand_tuple();
    tuple_t t;
    logic [15:0] s;
    s = 16'($urandom);
    t.i = 4'($urandom); t.rs1 = 5'($urandom); t.rs2 = 5'($urandom); t.rd = 5'($urandom);
    t.iv = ($urandom_range(0, 1) == 1) ? 32'($urandom) : {{16{s[15]}}, s};
    t.dle = 1'($urandom); t.dwe = 1'($urandom); t.iv_alu = 1'($urandom); t.pc_alu = 1'($urandom);
    t.pc_cmd = 2'($urandom); t.pc_val = 2'($urandom);
    case ($urandom_range(0, 5))
      0: begin t.pc_alu = 0; t.iv_alu = 0; end
      1: begin t.pc_alu = 0; t.iv_alu = 1; t.pc_cmd = 0; t.dle = 0; t.dwe = 0; end
      2: begin
        t.pc_alu = 0; t.iv_alu = 1; t.pc_cmd = 2'($urandom_range(2, 3));
        case ($urandom_range(0, 3)) 0: t.i = 8; 1: t.i = 9; 2: t.i = 15; default: t.i = 0; endcase
      end
      3: begin
        t.pc_alu = 1; t.pc_cmd = 2'b10;
        t.pc_val = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b01;
        if ($urandom_range(0, 1) == 1) begin t.i = 15; t.rd = 31; end else begin t.i = 0; t.rd = 0; end
      end
      4: begin
        t.pc_alu = 0; t.iv_alu = 1; t.pc_cmd = 0;
        if ($urandom_range(0, 3) != 0) t.i = 1;
      end
      default: ;
    endcase
    return t;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_tuple(blank());
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (out_word !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_out_word: got %h want 0", out_word); end
    compared++; if (out_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_out_addr: got %h want 0", out_addr); end
    compared++; if ({err, err_count} !== 9'h0) begin mismatched++; $display("[TB] FAIL reset_err: got %b/%0d want 0/0", err, err_count); end
  endtask

  task automatic test_add();
    tuple_t t;
    do_reset();
    t = blank(); t.i = 1; t.rs1 = 1; t.rs2 = 2; t.rd = 3;
    set_tuple(t); in_valid = 1; out_ready = 1;
    @(posedge clk); @(negedge clk); in_valid = 0;
    compared++; if (out_valid !== 1'b1 || out_word !== 32'h00221820) begin mismatched++; $display("[TB] FAIL add_word: got v=%b %h want v=1 00221820", out_valid, out_word); end
    compared++; if (out_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL add_addr: got %h want 0", out_addr); end
    @(posedge clk); @(negedge clk);
    compared++; if (out_valid !== 1'b0 || out_addr !== 32'h4) begin mismatched++; $display("[TB] FAIL add_drain: got v=%b addr=%h want v=0 addr=4", out_valid, out_addr); end
  endtask

  task automatic test_back_to_back();
    tuple_t t;
    do_reset();
    t = blank(); t.i = 1; t.iv_alu = 1; t.rs1 = 4; t.rs2 = 5; t.iv = 32'hFFFFFFFF;
    set_tuple(t); in_valid = 1; out_ready = 1;
    @(posedge clk); @(negedge clk);
    compared++; if (out_valid !== 1'b1 || out_word !== 32'h2085FFFF || out_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL b2b_addi: got v=%b %h @%h want v=1 2085ffff @0", out_valid, out_word, out_addr); end
    t = blank(); t.pc_alu = 1; t.pc_cmd = 2'b10; t.pc_val = 2'b01; t.i = 15; t.rd = 31; t.iv = 32'hFFFFFFFC;
    set_tuple(t);
    @(posedge clk); @(negedge clk); in_valid = 0;
    compared++; if (out_valid !== 1'b1 || out_word !== 32'h0FFFFFFC || out_addr !== 32'h4) begin mismatched++; $display("[TB] FAIL b2b_jal: got v=%b %h @%h want v=1 0ffffffc @4", out_valid, out_word, out_addr); end
    @(posedge clk); @(negedge clk);
    compared++; if (out_valid !== 1'b0 || out_addr !== 32'h8) begin mismatched++; $display("[TB] FAIL b2b_drain: got v=%b @%h want v=0 @8", out_valid, out_addr); end
  endtask

  task automatic test_backpressure();
    tuple_t t;
    do_reset();
    t = blank(); t.dwe = 1; t.i = 1; t.iv_alu = 1; t.rs1 = 2; t.rs2 = 7; t.iv = 32'h8;
    set_tuple(t); in_valid = 1; out_ready = 0;
    @(posedge clk); @(negedge clk); in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      compared++; if (out_valid !== 1'b1 || out_word !== 32'hAC470008 || out_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL bp_hold%0d: got v=%b %h @%h want v=1 ac470008 @0", c, out_valid, out_word, out_addr); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready%0d: got %b want 0", c, in_ready); end
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1; #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_in_ready_rise: got %b want 1", in_ready); end
    @(posedge clk); @(negedge clk);
    compared++; if (out_valid !== 1'b0 || out_addr !== 32'h4) begin mismatched++; $display("[TB] FAIL bp_consume: got v=%b @%h want v=0 @4", out_valid, out_addr); end
    @(posedge clk); @(negedge clk);
    compared++; if (out_addr !== 32'h4) begin mismatched++; $display("[TB] FAIL bp_single: got @%h want @4", out_addr); end
  endtask

  task automatic test_errors();
    tuple_t t;
    do_reset();
    t = blank(); t.i = 9; t.rs1 = 3;
    set_tuple(t); in_valid = 1; out_ready = 1;
    @(posedge clk); @(negedge clk);
    compared++; if (err !== 1'b1 || err_count !== 8'd1) begin mismatched++; $display("[TB] FAIL err_first: got %b/%0d want 1/1", err, err_count); end
    compared++; if (out_valid !== 1'b0 || out_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL err_no_word: got v=%b @%h want v=0 @0", out_valid, out_addr); end
    for (int n = 0; n < 256; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 99) begin
        compared++; if (err_count !== 8'd101) begin mismatched++; $display("[TB] FAIL err_count_mid: got %0d want 101", err_count); end
      end
    end
    in_valid = 0;
    compared++; if (err !== 1'b1 || err_count !== 8'd255) begin mismatched++; $display("[TB] FAIL err_saturate: got %b/%0d want 1/255", err, err_count); end
    compared++; if (out_valid !== 1'b0 || out_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL err_addr_held: got v=%b @%h want v=0 @0", out_valid, out_addr); end
  endtask

  task automatic test_reject_drain();
    tuple_t t;
    do_reset();
    t = blank(); t.i = 2; t.rs1 = 6; t.rs2 = 7; t.rd = 8;
    set_tuple(t); in_valid = 1; out_ready = 0;
    @(posedge clk); @(negedge clk);
    t = blank(); t.pc_alu = 1; t.pc_cmd = 2'b10; t.pc_val = 2'b01; t.i = 15; t.rd = 30;
    set_tuple(t); out_ready = 1;
    @(posedge clk); @(negedge clk); in_valid = 0;
    compared++; if (out_valid !== 1'b0 || out_addr !== 32'h4 || err_count !== 8'd1) begin mismatched++; $display("[TB] FAIL reject_drain: got v=%b @%h cnt=%0d want v=0 @4 cnt=1", out_valid, out_addr, err_count); end
  endtask

  task automatic test_range();
    tuple_t t;
    do_reset();
    t = blank(); t.i = 3; t.iv_alu = 1; t.iv = 32'h00010000;
    set_tuple(t); in_valid = 1; out_ready = 0;
    @(posedge clk); @(negedge clk); in_valid = 0;
`ifdef ENCODER_RANGE_CHECK_EN
    compared++; if (err !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL andi_range: got err=%b v=%b want err=1 v=0", err, out_valid); end
`else
    compared++; if (out_valid !== 1'b1 || out_word !== 32'h30000000 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL andi_trunc: got v=%b %h err=%b want v=1 30000000 err=0", out_valid, out_word, err); end
`endif
  endtask

  task automatic test_mid_reset();
    tuple_t t;
    do_reset();
    t = blank(); t.i = 9;
    set_tuple(t); in_valid = 1; out_ready = 1;
    @(posedge clk); @(negedge clk);
    t = blank(); t.i = 4; t.rs1 = 9; t.rd = 1;
    set_tuple(t); out_ready = 0;
    @(posedge clk); @(negedge clk); in_valid = 0;
    compared++; if (out_valid !== 1'b1 || err_count !== 8'd1) begin mismatched++; $display("[TB] FAIL midrst_setup: got v=%b cnt=%0d want v=1 cnt=1", out_valid, err_count); end
    reset_n = 0;
    @(posedge clk); @(negedge clk);
    reset_n = 1;
    compared++; if (out_valid !== 1'b0 || out_addr !== 32'h0 || out_word !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_out: got v=%b @%h %h want v=0 @0 0", out_valid, out_addr, out_word); end
    compared++; if (err !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_err: got err=%b cnt=%0d rdy=%b want 0/0/1", err, err_count, in_ready); end
  endtask

  task automatic test_random();
    tuple_t t;
    bit m_valid, m_err, ok, acc;
    logic [31:0] m_word, m_addr, w;
    int m_cnt;
    do_reset();
    m_valid = 0; m_err = 0; m_word = 32'h0; m_addr = 32'h0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      compared++; if (out_valid !== m_valid) begin mismatched++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, out_valid, m_valid); end
      if (m_valid) begin
        compared++; if (out_word !== m_word) begin mismatched++; $display("[TB] FAIL rnd_word c%0d: got %h want %h", c, out_word, m_word); end
      end
      compared++; if (out_addr !== m_addr) begin mismatched++; $display("[TB] FAIL rnd_addr c%0d: got %h want %h", c, out_addr, m_addr); end
      compared++; if (err !== m_err || err_count !== 8'(m_cnt)) begin mismatched++; $display("[TB] FAIL rnd_err c%0d: got %b/%0d want %b/%0d", c, err, err_count, m_err, m_cnt); end
      t = rand_tuple();
      set_tuple(t);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && (!m_valid || out_ready);
      compared++; if (in_ready !== (!m_valid || out_ready)) begin mismatched++; $display("[TB] FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, !m_valid || out_ready); end
      if (m_valid && out_ready) begin m_valid = 0; m_addr = m_addr + 32'd4; end
      if (acc) begin
        ref_encode(t, ok, w);
        if (ok) begin m_valid = 1; m_word = w; end
        else begin m_err = 1; if (m_cnt < 255) m_cnt++; end
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reject_drain();
    test_range();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
